muldiv_sequencer: RTL

- Iterative multi-cycle multiply/divide unit for the RV32M extension, placed beside the main ALU in the EX stage.
- Accepts one operation per start pulse and raises busy for its whole duration; hazard logic uses busy to stall the pipeline.
- Delivers a single-cycle done pulse with the result held stable afterwards.
- Operation is selected by the instruction's funct3 once decode has identified an M-type instruction (funct7 = 0000001).

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_datapath.sv | 120 ++++++++++++
 rtl/muldiv_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    // funct7 value that marks an R-type instruction as an M-extension op
    localparam logic [6:0] FUNCT7_M = 7'b0000001;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIXUP,
        S_DONE
    } state_t;

    // rs1 is treated as two's complement for these ops
    function automatic logic a_signed(input logic [2:0] f3);
        return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

    // rs2 is treated as two's complement for these ops
    function automatic logic b_signed(input logic [2:0] f3);
        return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Operand capture, magnitude conditioning, shift-add / restoring-divide
// accumulator and final sign fixup for the multiply/divide sequencer.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            capture,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            special,
    output logic [XLEN-1:0] special_word,
    output logic [XLEN-1:0] fix_word
);

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v);
        return -v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_wide(input logic [2*XLEN-1:0] v);
        return -v;
    endfunction

    logic [2:0]        f3_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   mag_b;
    logic [2*XLEN-1:0] acc;
    logic              neg_q;
    logic              neg_r;

    logic              sa;
    logic              sb;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN:0]     msum;
    logic [XLEN:0]     dtrial;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    // operand magnitudes, short-circuit detection and the per-cycle step arithmetic
    always_comb begin
        sa       = a_signed(f3_q) & a_q[XLEN-1];
        sb       = b_signed(f3_q) & b_q[XLEN-1];
        abs_a    = sa ? neg_word(a_q) : a_q;
        abs_b    = sb ? neg_word(b_q) : b_q;
        div_zero = f3_q[2] && (b_q == '0);
        div_ovf  = ((f3_q == MD_DIV) || (f3_q == MD_REM)) && (a_q == MIN_VAL) && (b_q == '1);
        special  = div_zero || div_ovf;
        if (div_zero) begin
            special_word = f3_q[1] ? a_q : '1;
        end else begin
            special_word = f3_q[1] ? '0 : MIN_VAL;
        end
        // multiply: add multiplicand into the high half when the current multiplier bit is set
        msum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
        // divide: partial remainder after the left shift, minus divisor; MSB is the borrow
        dtrial = acc[2*XLEN-1:XLEN-1] - {1'b0, mag_b};
    end

    // sign correction and output word selection
    always_comb begin
        prod_fix = neg_q ? neg_wide(acc) : acc;
        quo_fix  = neg_q ? neg_word(acc[XLEN-1:0]) : acc[XLEN-1:0];
        rem_fix  = neg_r ? neg_word(acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
        case (f3_q)
            MD_MUL:                         fix_word = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:   fix_word = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:                fix_word = quo_fix;
            MD_REM, MD_REMU:                fix_word = rem_fix;
            default:                        fix_word = '0;
        endcase
    end

    // operand latch, accumulator initialisation and one iteration per step strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            mag_b <= '0;
            acc   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            if (capture) begin
                f3_q <= funct3;
                a_q  <= op_a;
                b_q  <= op_b;
            end
            if (load) begin
                acc   <= {{XLEN{1'b0}}, abs_a};
                mag_b <= abs_b;
                neg_q <= sa ^ sb;
                neg_r <= sa;
            end else if (step) begin
                if (f3_q[2]) begin
                    if (!dtrial[XLEN]) begin
                        acc <= {dtrial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                    end else begin
                        acc <= {acc[2*XLEN-2:0], 1'b0};
                    end
                end else begin
                    acc <= {msum, acc[XLEN-1:1]};
                end
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M iterative multiply/divide unit: control FSM, iteration counter and
// result register around the shared shift/add-subtract datapath.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             capture;
    logic             load;
    logic             step;
    logic             special;
    logic [XLEN-1:0]  special_word;
    logic [XLEN-1:0]  fix_word;

    // datapath strobes decoded from the current state
    always_comb begin
        capture = (state == S_IDLE) && start && !flush;
        load    = (state == S_PREP);
        step    = (state == S_RUN);
    end

    muldiv_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .clk          (clk),
        .rst_n        (rst_n),
        .capture      (capture),
        .load         (load),
        .step         (step),
        .funct3       (funct3),
        .op_a         (op_a),
        .op_b         (op_b),
        .special      (special),
        .special_word (special_word),
        .fix_word     (fix_word)
    );

    // control FSM; flush overrides all progression and never touches result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state <= S_PREP;
                            busy  <= 1'b1;
                        end
                    end
                    S_PREP: begin
                        if (special) begin
                            result <= special_word;
                            state  <= S_DONE;
                            done   <= 1'b1;
                        end else begin
                            cnt   <= CNT_W'(XLEN);
                            state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= S_FIXUP;
                        end
                    end
                    S_FIXUP: begin
                        result <= fix_word;
                        state  <= S_DONE;
                        done   <= 1'b1;
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
